// File: rtl/bypass_rf_wb_queue_pkg.sv
// Shared definitions for the register-file writeback queue: entry lifecycle encoding and
// width defaults common with the bypassing register file.
package bypass_rf_wb_queue_pkg;

    localparam int unsigned DefaultDataWidth = 1;
    localparam int unsigned DefaultNameWidth = 1;

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StAlloc     = 3'd1,
        StHeld      = 3'd2,
        StWritten   = 3'd3,
        StCommitted = 3'd4
    } entry_state_e;

endpackage

// File: rtl/bypass_rf_oldest2_pick.sv
// Rotating-priority selector: finds the first two set bits of a vector, scanning upward
// from a start index and wrapping, so the start position is treated as the oldest.
module bypass_rf_oldest2_pick
    import bypass_rf_wb_queue_pkg::*;
#(
    parameter int unsigned name_width = DefaultNameWidth,
    parameter int unsigned numNames   = 2 ** name_width
) (
    input  logic [numNames-1:0]   held,
    input  logic [name_width-1:0] start,
    output logic                  valid_1,
    output logic [name_width-1:0] idx_1,
    output logic                  valid_2,
    output logic [name_width-1:0] idx_2
);

    logic [name_width-1:0] scan_idx;

    always_comb begin
        valid_1  = 1'b0;
        idx_1    = '0;
        valid_2  = 1'b0;
        idx_2    = '0;
        scan_idx = '0;
        for (int unsigned i = 0; i < numNames; i++) begin
            // Name arithmetic wraps naturally at name_width bits.
            scan_idx = start + name_width'(i);
            if (held[scan_idx]) begin
                if (!valid_1) begin
                    valid_1 = 1'b1;
                    idx_1   = scan_idx;
                end else if (!valid_2) begin
                    valid_2 = 1'b1;
                    idx_2   = scan_idx;
                end
            end
        end
    end

endmodule

// File: rtl/bypass_rf_wb_queue.sv
// Writeback queue in front of the bypassing register file: captures tagged results, drains
// the two oldest per cycle to the write ports, retires in order and issues registered frees.
module bypass_rf_wb_queue
    import bypass_rf_wb_queue_pkg::*;
#(
    parameter int unsigned data_width = DefaultDataWidth,
    parameter int unsigned name_width = DefaultNameWidth,
    parameter int unsigned numNames   = 2 ** name_width
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  ALLOC_FIRE,
    input  logic [name_width-1:0] ALLOC_NAME,
    input  logic                  RES_VALID_1,
    input  logic [name_width-1:0] RES_NAME_1,
    input  logic [data_width-1:0] RES_DATA_1,
    input  logic                  RES_VALID_2,
    input  logic [name_width-1:0] RES_NAME_2,
    input  logic [data_width-1:0] RES_DATA_2,
    output logic                  RES_READY_1,
    output logic                  RES_READY_2,
    output logic                  WR_EN_1,
    output logic [name_width-1:0] WR_NAME_1,
    output logic [data_width-1:0] WR_DATA_1,
    output logic                  WR_EN_2,
    output logic [name_width-1:0] WR_NAME_2,
    output logic [data_width-1:0] WR_DATA_2,
    input  logic                  COMMIT_E,
    output logic                  COMMIT_READY,
    output logic                  FREE_EN,
    output logic [name_width-1:0] FREE_NAME,
    input  logic                  FREE_READY,
    output logic                  ERR
);

    entry_state_e          state_q [numNames];
    entry_state_e          state_d [numNames];
    logic [data_width-1:0] data_q  [numNames];
    logic [data_width-1:0] data_d  [numNames];

    logic [name_width-1:0] commit_ptr_q, commit_ptr_d;
    logic [name_width-1:0] free_ptr_q, free_ptr_d;
    logic [name_width-1:0] free_name_q, free_name_d;
    logic                  free_en_q, free_en_d;
    logic                  err_q, err_d;

    logic [numNames-1:0]   held_vec;
    logic                  pick_v1, pick_v2;
    logic [name_width-1:0] pick_i1, pick_i2;
    logic [name_width-1:0] free_ptr_nxt;
    logic                  res_ok_1, res_ok_2;

    always_comb begin
        held_vec = '0;
        for (int unsigned i = 0; i < numNames; i++) begin
            held_vec[i] = (state_q[i] == StHeld);
        end
    end

    bypass_rf_oldest2_pick #(
        .name_width (name_width),
        .numNames   (numNames)
    ) u_pick (
        .held    (held_vec),
        .start   (free_ptr_q),
        .valid_1 (pick_v1),
        .idx_1   (pick_i1),
        .valid_2 (pick_v2),
        .idx_2   (pick_i2)
    );

    assign RES_READY_1  = 1'b1;
    assign RES_READY_2  = 1'b1;
    assign WR_EN_1      = pick_v1;
    assign WR_NAME_1    = pick_i1;
    assign WR_DATA_1    = data_q[pick_i1];
    assign WR_EN_2      = pick_v2;
    assign WR_NAME_2    = pick_i2;
    assign WR_DATA_2    = data_q[pick_i2];
    assign COMMIT_READY = (state_q[commit_ptr_q] == StWritten);
    assign FREE_EN      = free_en_q;
    assign FREE_NAME    = free_name_q;
    assign ERR          = err_q;
    assign free_ptr_nxt = free_ptr_q + name_width'(1);

    // A result racing an alloc of its own name, or losing a same-name tie, is dropped.
    assign res_ok_1 = (state_q[RES_NAME_1] == StAlloc) &&
                      !(ALLOC_FIRE && (ALLOC_NAME == RES_NAME_1));
    assign res_ok_2 = (state_q[RES_NAME_2] == StAlloc) &&
                      !(ALLOC_FIRE && (ALLOC_NAME == RES_NAME_2)) &&
                      !(RES_VALID_1 && (RES_NAME_1 == RES_NAME_2));

    // Every transition below starts from a distinct state, so no two can hit one entry.
    always_comb begin
        state_d      = state_q;
        data_d       = data_q;
        commit_ptr_d = commit_ptr_q;
        free_ptr_d   = free_ptr_q;
        free_name_d  = free_name_q;
        free_en_d    = free_en_q;
        err_d        = err_q;

        if (ALLOC_FIRE) begin
            if (state_q[ALLOC_NAME] == StIdle) state_d[ALLOC_NAME] = StAlloc;
            else                               err_d = 1'b1;
        end

        if (RES_VALID_1) begin
            if (res_ok_1) begin
                state_d[RES_NAME_1] = StHeld;
                data_d[RES_NAME_1]  = RES_DATA_1;
            end else begin
                err_d = 1'b1;
            end
        end
        if (RES_VALID_2) begin
            if (res_ok_2) begin
                state_d[RES_NAME_2] = StHeld;
                data_d[RES_NAME_2]  = RES_DATA_2;
            end else begin
                err_d = 1'b1;
            end
        end

        if (pick_v1) state_d[pick_i1] = StWritten;
        if (pick_v2) state_d[pick_i2] = StWritten;

        if (COMMIT_E) begin
            if (COMMIT_READY) begin
                state_d[commit_ptr_q] = StCommitted;
                commit_ptr_d          = commit_ptr_q + name_width'(1);
            end else begin
                err_d = 1'b1;
            end
        end

        if (!free_en_q) begin
            if (state_q[free_ptr_q] == StCommitted) begin
                free_en_d   = 1'b1;
                free_name_d = free_ptr_q;
            end
        end else if (FREE_READY) begin
            state_d[free_ptr_q] = StIdle;
            free_ptr_d          = free_ptr_nxt;
            free_name_d         = free_ptr_nxt;
            free_en_d           = (state_q[free_ptr_nxt] == StCommitted);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int unsigned i = 0; i < numNames; i++) begin
                state_q[i] <= StIdle;
                data_q[i]  <= '0;
            end
            commit_ptr_q <= '0;
            free_ptr_q   <= '0;
            free_name_q  <= '0;
            free_en_q    <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            data_q       <= data_d;
            commit_ptr_q <= commit_ptr_d;
            free_ptr_q   <= free_ptr_d;
            free_name_q  <= free_name_d;
            free_en_q    <= free_en_d;
            err_q        <= err_d;
        end
    end

endmodule
